// File: rtl/booth_pkg.sv
// Shared definitions for the radix-16 Booth sequential multiplier.
// Holds the controller state type, the digit shift and the digit-count helper.
package booth_pkg;

  localparam int unsigned RADIX_SHIFT = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Unsigned operands need one extra digit so B's MSB lands in a positive top window
  function automatic int unsigned digits(input int unsigned length, input bit unsigned_booth);
    return unsigned_booth ? (length / RADIX_SHIFT) + 1 : (length / RADIX_SHIFT);
  endfunction

endpackage

// File: rtl/booth_r16_seq_mul_booth_ctrl.sv
// Radix-16 Booth encoder: turns one 5-bit multiplier window into the
// signed partial product digit*A, LENGTH+4 bits wide.
module booth_r16_seq_mul_booth_ctrl #(
  parameter int unsigned LENGTH         = 32,
  parameter bit          UNSINGED_BOOTH = 1'b1
) (
  input  logic [LENGTH-1:0] a_i,
  input  logic [4:0]        b_i,
  output logic [LENGTH+3:0] bo_o
);

  localparam int unsigned PP_W = LENGTH + 4;

  logic signed [4:0]      digit;
  logic signed [PP_W-1:0] a_ext;
  logic signed [PP_W-1:0] digit_ext;

  // digit = -8*w4 + 4*w3 + 2*w2 + w1 + w0, always within [-8, 8]
  always_comb begin
    digit     = $signed({b_i[4], b_i[4:1]}) + $signed({4'b0000, b_i[0]});
    a_ext     = UNSINGED_BOOTH ? $signed({4'b0000, a_i})
                               : $signed({{4{a_i[LENGTH-1]}}, a_i});
    digit_ext = PP_W'(digit);
    bo_o      = a_ext * digit_ext;
  end

endmodule

// File: rtl/booth_r16_seq_mul.sv
// Iterative radix-16 Booth multiplier: one window per cycle through the encoder,
// partial products shifted by 4*k and accumulated into a 2*LENGTH product.
module booth_r16_seq_mul
  import booth_pkg::*;
#(
  parameter int unsigned LENGTH         = 32,
  parameter bit          UNSINGED_BOOTH = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [LENGTH-1:0]     a_i,
  input  logic [LENGTH-1:0]     b_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [2*LENGTH-1:0]   product_o
);

  localparam int unsigned N       = digits(LENGTH, UNSINGED_BOOTH);
  localparam int unsigned BEXT_W  = RADIX_SHIFT * N;
  localparam int unsigned PP_W    = LENGTH + 4;
  localparam int unsigned PROD_W  = 2 * LENGTH;
  localparam int unsigned CNT_W   = $clog2(N + 1);
  localparam int unsigned SHAMT_W = $clog2(PROD_W);

  state_e              state_q, state_d;
  logic                accept, add, last;
  logic [LENGTH-1:0]   a_q;
  logic [BEXT_W-1:0]   b_ext, b_sh_q;
  logic                b_prev_q;
  logic [PROD_W-1:0]   acc_q, acc_sum;
  logic [CNT_W-1:0]    cnt_q;
  logic [SHAMT_W-1:0]  shamt;
  logic [4:0]          window;
  logic [PP_W-1:0]     pp;

  booth_r16_seq_mul_booth_ctrl #(
    .LENGTH         (LENGTH),
    .UNSINGED_BOOTH (UNSINGED_BOOTH)
  ) u_booth_ctrl (
    .a_i  (a_q),
    .b_i  (window),
    .bo_o (pp)
  );

  // B is consumed four bits per cycle; b_prev_q carries the overlap bit (b_ext[-1]=0)
  always_comb begin
    b_ext   = UNSINGED_BOOTH ? BEXT_W'(b_i) : BEXT_W'($signed(b_i));
    window  = {b_sh_q[RADIX_SHIFT-1:0], b_prev_q};
    shamt   = SHAMT_W'(cnt_q) * SHAMT_W'(RADIX_SHIFT);
    acc_sum = acc_q + (PROD_W'($signed(pp)) << shamt);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Output handshake has priority: DONE never accepts new operands
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    add     = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid_i && in_ready_o) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        add = 1'b1;
        if (cnt_q == CNT_W'(N - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_ready_o  <= 1'b0;
      out_valid_o <= 1'b0;
      product_o   <= '0;
      a_q         <= '0;
      b_sh_q      <= '0;
      b_prev_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      in_ready_o  <= (state_d == IDLE);
      out_valid_o <= (state_d == DONE);
      if (accept) begin
        a_q      <= a_i;
        b_sh_q   <= b_ext;
        b_prev_q <= 1'b0;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (add) begin
        acc_q    <= acc_sum;
        b_sh_q   <= b_sh_q >> RADIX_SHIFT;
        b_prev_q <= b_sh_q[RADIX_SHIFT-1];
        if (last) product_o <= acc_sum;
        else      cnt_q     <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/booth_r16_seq_mul.md
Name: booth_r16_seq_mul

Overview:
- Iterative radix-16 Booth multiplier datapath and controller.
- Sits directly downstream of the Booth_Ctrl encoder: it slices multiplier B into 5-bit overlapping windows, drives the encoder one window per cycle, and consumes each signed LENGTH+4-bit partial product.
- Shifts each partial product by 4*k and accumulates it into a 2*LENGTH product.
- Valid/ready handshakes on input and output; one multiplication in flight.

Parameters:
- LENGTH, 32: operand width. Must be a multiple of 4 and at least 8.
- UNSINGED_BOOTH, 1'b1: 1 = unsigned operands, 0 = two's-complement. Passed unchanged to Booth_Ctrl.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- in_valid_i  input  1  operands valid.
- in_ready_o  output  1  block can accept operands.
- a_i  input  LENGTH  multiplicand A.
- b_i  input  LENGTH  multiplier B (Booth-recoded).
- out_valid_o  output  1  product valid.
- out_ready_i  input  1  consumer accepts product.
- product_o  output  2*LENGTH  A*B.

Behaviour:
- Digit count N:
  - N = LENGTH/4 + 1 when UNSINGED_BOOTH=1 (9 for LENGTH=32). The top digit absorbs B's MSB as positive.
  - N = LENGTH/4 when UNSINGED_BOOTH=0 (8).
- b_ext is 4N bits: B zero-extended (unsigned) or sign-extended (signed).
- Window for digit k is {b_ext[4k+3:4k], b_ext[4k-1]}, with b_ext[-1]=0.
- Digit value = -8*w4+4*w3+2*w2+w1+w0, in the range [-8,8].
- Partial product pp_k (LENGTH+4 bits, signed) comes from Booth_Ctrl.
- Accumulator update: acc += sext(pp_k) << 4k, computed modulo 2^(2*LENGTH). The true result always fits, so the truncation is exact.
- FSM states IDLE, CALC, DONE. Encoding is free; the reset state is IDLE.
  - IDLE:
    - in_ready_o=1.
    - On in_valid_i & in_ready_o: latch a_i and b_ext, clear acc, cnt<=0, go to CALC.
  - CALC:
    - in_ready_o=0.
    - Each cycle: acc += shifted pp_cnt, cnt<=cnt+1.
    - When cnt==N-1, perform the last add and go to DONE.
  - DONE:
    - out_valid_o=1, product_o=acc.
    - On out_ready_i: go to IDLE (out_valid_o=0 next cycle).
    - Without out_ready_i: product_o and out_valid_o are held stable.
- Latency: accept on edge E. Exactly N add cycles follow (edges E+1..E+N). out_valid_o is high from edge E+N. Minimum issue interval is N+2 cycles.
- Output handshake takes priority: no new operand is accepted in DONE, even if in_valid_i is high.
- Inputs a_i/b_i are ignored outside the accept cycle. Changing them during CALC has no effect.
- in_valid_i is not required to be held. Dropping it while in_ready_o=0 is legal and loses nothing already accepted.
- Operand values:
  - B=0 or A=0 yields product 0 after the full N cycles. There is no early termination.
  - Unsigned all-ones operands and signed most-negative operands must give exact results (see Test Plan).
- Reset (rst_i high, any time, including mid-CALC or in DONE):
  - Immediately forces IDLE; the in-flight operation is discarded.
  - Asynchronous reset values: out_valid_o=0, product_o=0, acc=0, cnt=0.
  - in_ready_o=0 while rst_i is high; it goes to 1 on the first clock after rst_i deasserts.
- cnt width: $clog2(N+1). It never wraps beyond N-1 in CALC.

Decomposition:
- Shared package (booth_pkg): FSM state typedef (IDLE/CALC/DONE), function digits(LENGTH, UNSINGED_BOOTH) returning N, constant RADIX_SHIFT=4.
- One sub-module: the existing Booth_Ctrl encoder, instantiated once with a_i=latched A and b_i=current window, bo_o=pp.
- Window mux, shifter, accumulator and FSM live in booth_r16_seq_mul.

Test Plan:
1. Unsigned, LENGTH=32. A=3, B=5, out_ready_i=1, accept at edge 0 -> in_ready_o low on edges 1-9, out_valid_o high after edge 9, product_o=64'h0F, in_ready_o high two cycles later.
2. Unsigned. A=B=32'hFFFFFFFF -> product_o=64'hFFFFFFFE00000001. A=32'h80000000, B=2 -> 64'h100000000.
3. Signed (UNSINGED_BOOTH=0). A=B=32'hFFFFFFFF -> 64'h1 after 8 add cycles. A=B=32'h80000000 -> 64'h4000000000000000. A=32'h80000000, B=1 -> 64'hFFFFFFFF80000000.
4. Backpressure. out_ready_i low for 5 cycles after out_valid_o rises, in_valid_i held high with new operands -> product_o stable, in_ready_o=0. The second operation is accepted only after the out handshake and produces its correct product.
5. Reset mid-CALC. Assert rst_i at add cycle 4 for 1 cycle -> out_valid_o=0 and product_o=0 immediately, no output for the aborted op. The next op A=7, B=9 gives 64'd63.
6. Random regression: 10k random A/B in both modes, with random in_valid_i/out_ready_i gaps -> every product matches a reference model, each appears exactly once, in order.
